// File: rtl/time_pkg.sv
// Shared encodings and field limits for the time-setting path.
package time_pkg;

    typedef logic [2:0] state_t;
    localparam state_t ST_RUN    = 3'd0;
    localparam state_t ST_SET_H  = 3'd1;
    localparam state_t ST_SET_M  = 3'd2;
    localparam state_t ST_SET_S  = 3'd3;
    localparam state_t ST_COMMIT = 3'd4;

    typedef logic [1:0] field_t;
    localparam field_t FIELD_NONE    = 2'd0;
    localparam field_t FIELD_HOURS   = 2'd1;
    localparam field_t FIELD_MINUTES = 2'd2;
    localparam field_t FIELD_SECONDS = 2'd3;

    localparam int unsigned HOURS_MAX = 23;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned SEC_MAX   = 59;

    function automatic logic [3:0] bcd_tens(input int unsigned v);
        return 4'((v / 10) % 10);
    endfunction

    function automatic logic [3:0] bcd_ones(input int unsigned v);
        return 4'(v % 10);
    endfunction

endpackage

// File: rtl/time_setter_if.sv
// Button, live-time and edited-time signals between time_setter and its neighbours.
interface time_setter_if #(
    parameter int unsigned DIGIT_W = 5
);
    logic               btn_mode;
    logic               btn_inc;
    logic               btn_dec;
    logic [DIGIT_W-1:0] cur_hours_tens;
    logic [DIGIT_W-1:0] cur_hours_ones;
    logic [DIGIT_W-1:0] cur_minutes_tens;
    logic [DIGIT_W-1:0] cur_minutes_ones;
    logic [DIGIT_W-1:0] cur_seconds_tens;
    logic [DIGIT_W-1:0] cur_seconds_ones;
    logic [DIGIT_W-1:0] set_hours_tens;
    logic [DIGIT_W-1:0] set_hours_ones;
    logic [DIGIT_W-1:0] set_minutes_tens;
    logic [DIGIT_W-1:0] set_minutes_ones;
    logic [DIGIT_W-1:0] set_seconds_tens;
    logic [DIGIT_W-1:0] set_seconds_ones;
    logic               load_strobe;
    logic               set_active;
    logic [1:0]         field_sel;

    modport master (
        input  btn_mode, btn_inc, btn_dec,
        input  cur_hours_tens, cur_hours_ones, cur_minutes_tens,
        input  cur_minutes_ones, cur_seconds_tens, cur_seconds_ones,
        output set_hours_tens, set_hours_ones, set_minutes_tens,
        output set_minutes_ones, set_seconds_tens, set_seconds_ones,
        output load_strobe, set_active, field_sel
    );

    modport slave (
        output btn_mode, btn_inc, btn_dec,
        output cur_hours_tens, cur_hours_ones, cur_minutes_tens,
        output cur_minutes_ones, cur_seconds_tens, cur_seconds_ones,
        input  set_hours_tens, set_hours_ones, set_minutes_tens,
        input  set_minutes_ones, set_seconds_tens, set_seconds_ones,
        input  load_strobe, set_active, field_sel
    );

endinterface

// File: rtl/bcd_pair_step.sv
// Steps a two-digit BCD value by +/-1 with wrap between 0 and a field maximum.
module bcd_pair_step (
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic [3:0] max_tens,
    input  logic [3:0] max_ones,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] next_tens,
    output logic [3:0] next_ones
);
    logic at_or_above_max;
    logic above_max;

    assign at_or_above_max = (tens > max_tens) || ((tens == max_tens) && (ones >= max_ones));
    assign above_max       = (tens > max_tens) || ((tens == max_tens) && (ones > max_ones));

    always_comb begin
        next_tens = tens;
        next_ones = ones;
        if (inc && !dec) begin
            if (at_or_above_max) begin
                next_tens = 4'd0;
                next_ones = 4'd0;
            end else if (ones >= 4'd9) begin
                next_tens = tens + 4'd1;
                next_ones = 4'd0;
            end else begin
                next_ones = ones + 4'd1;
            end
        end else if (dec && !inc) begin
            // Out-of-range captured values snap to the maximum on decrement.
            if (above_max || ((tens == 4'd0) && (ones == 4'd0))) begin
                next_tens = max_tens;
                next_ones = max_ones;
            end else if (ones == 4'd0) begin
                next_tens = tens - 4'd1;
                next_ones = 4'd9;
            end else begin
                next_ones = ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/time_setter.sv
// Button-driven editor: captures live time, edits h/m/s in turn, emits a load strobe.
module time_setter
    import time_pkg::*;
#(
    parameter int unsigned DIGIT_W        = 5,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000_000,
    parameter int unsigned TO_W           = 32
) (
    input logic           sys_clk,
    input logic           rst,
    time_setter_if.master bus
);
    state_t          state_q, state_d;
    logic [2:0]      btn_prev_q, btn_pulse_q;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      ht_q, ho_q, mt_q, mo_q, st_q, so_q;
    logic [3:0]      ht_d, ho_d, mt_d, mo_d, st_d, so_d;
    logic [3:0]      ht_step, ho_step, mt_step, mo_step, st_step, so_step;
    logic            load_strobe_q, set_active_q;
    field_t          field_sel_q, field_sel_d;
    logic            mode_p, inc_p, dec_p;

    function automatic logic [3:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        if (d > DIGIT_W'(9)) return 4'd9;
        return d[3:0];
    endfunction

    assign mode_p = btn_pulse_q[2];
    assign inc_p  = btn_pulse_q[1];
    assign dec_p  = btn_pulse_q[0];

    bcd_pair_step u_hours_step (
        .tens(ht_q), .ones(ho_q), .max_tens(bcd_tens(HOURS_MAX)), .max_ones(bcd_ones(HOURS_MAX)),
        .inc(inc_p), .dec(dec_p), .next_tens(ht_step), .next_ones(ho_step)
    );
    bcd_pair_step u_minutes_step (
        .tens(mt_q), .ones(mo_q), .max_tens(bcd_tens(MIN_MAX)), .max_ones(bcd_ones(MIN_MAX)),
        .inc(inc_p), .dec(dec_p), .next_tens(mt_step), .next_ones(mo_step)
    );
    bcd_pair_step u_seconds_step (
        .tens(st_q), .ones(so_q), .max_tens(bcd_tens(SEC_MAX)), .max_ones(bcd_ones(SEC_MAX)),
        .inc(inc_p), .dec(dec_p), .next_tens(st_step), .next_ones(so_step)
    );

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        {ht_d, ho_d, mt_d, mo_d, st_d, so_d} = {ht_q, ho_q, mt_q, mo_q, st_q, so_q};
        case (state_q)
            ST_RUN: begin
                if (mode_p) begin
                    ht_d    = clamp_digit(bus.cur_hours_tens);
                    ho_d    = clamp_digit(bus.cur_hours_ones);
                    mt_d    = clamp_digit(bus.cur_minutes_tens);
                    mo_d    = clamp_digit(bus.cur_minutes_ones);
                    st_d    = clamp_digit(bus.cur_seconds_tens);
                    so_d    = clamp_digit(bus.cur_seconds_ones);
                    state_d = ST_SET_H;
                end
            end
            ST_SET_H: begin
                if (mode_p) state_d = ST_SET_M;
                else {ht_d, ho_d} = {ht_step, ho_step};
            end
            ST_SET_M: begin
                if (mode_p) state_d = ST_SET_S;
                else {mt_d, mo_d} = {mt_step, mo_step};
            end
            ST_SET_S: begin
                if (mode_p) state_d = ST_COMMIT;
                else {st_d, so_d} = {st_step, so_step};
            end
            default: state_d = ST_RUN;
        endcase

        // Idle timeout: any pulse restarts the count; expiry abandons the edit.
        if (state_q inside {ST_SET_H, ST_SET_M, ST_SET_S}) begin
            if (|btn_pulse_q) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d  = ST_RUN;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end

        case (state_d)
            ST_SET_H: field_sel_d = FIELD_HOURS;
            ST_SET_M: field_sel_d = FIELD_MINUTES;
            ST_SET_S: field_sel_d = FIELD_SECONDS;
            default:  field_sel_d = FIELD_NONE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            btn_prev_q    <= '0;
            btn_pulse_q   <= '0;
            to_cnt_q      <= '0;
            {ht_q, ho_q, mt_q, mo_q, st_q, so_q} <= '0;
            load_strobe_q <= 1'b0;
            set_active_q  <= 1'b0;
            field_sel_q   <= FIELD_NONE;
        end else begin
            btn_prev_q    <= {bus.btn_mode, bus.btn_inc, bus.btn_dec};
            btn_pulse_q   <= {bus.btn_mode, bus.btn_inc, bus.btn_dec} & ~btn_prev_q;
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            {ht_q, ho_q, mt_q, mo_q, st_q, so_q} <= {ht_d, ho_d, mt_d, mo_d, st_d, so_d};
            load_strobe_q <= (state_d == ST_COMMIT);
            set_active_q  <= (state_d != ST_RUN);
            field_sel_q   <= field_sel_d;
        end
    end

    assign bus.set_hours_tens   = DIGIT_W'(ht_q);
    assign bus.set_hours_ones   = DIGIT_W'(ho_q);
    assign bus.set_minutes_tens = DIGIT_W'(mt_q);
    assign bus.set_minutes_ones = DIGIT_W'(mo_q);
    assign bus.set_seconds_tens = DIGIT_W'(st_q);
    assign bus.set_seconds_ones = DIGIT_W'(so_q);
    assign bus.load_strobe      = load_strobe_q;
    assign bus.set_active       = set_active_q;
    assign bus.field_sel        = field_sel_q;

endmodule

// File: tb/tb_time_setter.sv
// Directed test of time_setter: capture, edit, wrap, priority, timeout and reset.
module tb_time_setter;
    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    time_setter_if #(.DIGIT_W(5)) bus ();

    time_setter #(
        .DIGIT_W(5),
        .TIMEOUT_CYCLES(20),
        .TO_W(32)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus.cur_hours_tens   = 5'(h / 10);
        bus.cur_hours_ones   = 5'(h % 10);
        bus.cur_minutes_tens = 5'(m / 10);
        bus.cur_minutes_ones = 5'(m % 10);
        bus.cur_seconds_tens = 5'(s / 10);
        bus.cur_seconds_ones = 5'(s % 10);
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        @(negedge sys_clk);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.btn_dec  = d;
        tick(2);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b0;
        #100;
        @(negedge sys_clk);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        set_cur(12, 34, 56);
        do_reset();
        checks++;
        if ({bus.set_hours_tens, bus.set_hours_ones, bus.set_minutes_tens, bus.set_minutes_ones,
             bus.set_seconds_tens, bus.set_seconds_ones} !== 30'd0) begin
            errors++;
            $display("FAIL reset_digits: got %h want 0", {bus.set_hours_tens, bus.set_hours_ones});
        end
        checks++;
        if ({bus.load_strobe, bus.set_active, bus.field_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.load_strobe, bus.set_active, bus.field_sel});
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.set_active, bus.field_sel, bus.set_hours_ones} !== {1'b0, 2'd0, 5'd0}) begin
            errors++;
            $display("FAIL run_inc_ignored: got act=%b fs=%0d ho=%0d want 0 0 0",
                     bus.set_active, bus.field_sel, bus.set_hours_ones);
        end
    endtask

    task automatic test_capture_commit();
        int highs;
        logic ok_vals;
        highs   = 0;
        ok_vals = 1'b1;
        do_reset();
        set_cur(12, 34, 56);
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.field_sel, bus.set_active, bus.set_hours_tens, bus.set_hours_ones,
             bus.set_seconds_tens, bus.set_seconds_ones} !== {2'd1, 1'b1, 5'd1, 5'd2, 5'd5, 5'd6})
        begin
            errors++;
            $display("FAIL capture: got fs=%0d h=%0d%0d s=%0d%0d want 1 12 56", bus.field_sel,
                     bus.set_hours_tens, bus.set_hours_ones, bus.set_seconds_tens,
                     bus.set_seconds_ones);
        end
        repeat (3) press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.set_hours_tens, bus.set_hours_ones} !== {5'd1, 5'd5}) begin
            errors++;
            $display("FAIL hours_inc3: got %0d%0d want 15", bus.set_hours_tens, bus.set_hours_ones);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if ({bus.field_sel, bus.set_minutes_tens, bus.set_minutes_ones} !== {2'd2, 5'd3, 5'd3})
        begin
            errors++;
            $display("FAIL minutes_dec: got fs=%0d m=%0d%0d want 2 33", bus.field_sel,
                     bus.set_minutes_tens, bus.set_minutes_ones);
        end
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.field_sel !== 2'd3) begin
            errors++;
            $display("FAIL enter_seconds: got %0d want 3", bus.field_sel);
        end
        @(negedge sys_clk);
        bus.btn_mode = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 2) bus.btn_mode = 1'b0;
            if (bus.load_strobe === 1'b1) begin
                highs++;
                if ({bus.set_hours_tens, bus.set_hours_ones, bus.set_minutes_tens,
                     bus.set_minutes_ones, bus.set_seconds_tens, bus.set_seconds_ones} !==
                    {5'd1, 5'd5, 5'd3, 5'd3, 5'd5, 5'd6}) ok_vals = 1'b0;
            end
        end
        checks++;
        if (highs !== 1) begin
            errors++;
            $display("FAIL commit_strobe_len: got %0d cycles want 1", highs);
        end
        checks++;
        if (ok_vals !== 1'b1) begin
            errors++;
            $display("FAIL commit_values: got wrong digits during strobe want 15:33:56");
        end
        checks++;
        if ({bus.field_sel, bus.set_active} !== 3'b000) begin
            errors++;
            $display("FAIL after_commit: got fs=%0d act=%b want 0 0", bus.field_sel,
                     bus.set_active);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_cur(23, 0, 59);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.set_hours_tens, bus.set_hours_ones} !== 10'd0) begin
            errors++;
            $display("FAIL hours_wrap: got %0d%0d want 00", bus.set_hours_tens, bus.set_hours_ones);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if ({bus.set_minutes_tens, bus.set_minutes_ones} !== {5'd5, 5'd9}) begin
            errors++;
            $display("FAIL minutes_wrap: got %0d%0d want 59", bus.set_minutes_tens,
                     bus.set_minutes_ones);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.set_seconds_tens, bus.set_seconds_ones} !== 10'd0) begin
            errors++;
            $display("FAIL seconds_wrap: got %0d%0d want 00", bus.set_seconds_tens,
                     bus.set_seconds_ones);
        end
        do_reset();
        set_cur(9, 15, 30);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.set_hours_tens, bus.set_hours_ones} !== {5'd1, 5'd0}) begin
            errors++;
            $display("FAIL hours_bcd_carry: got %0d%0d want 10", bus.set_hours_tens,
                     bus.set_hours_ones);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_cur(12, 34, 56);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        checks++;
        if ({bus.set_hours_tens, bus.set_hours_ones} !== {5'd1, 5'd2}) begin
            errors++;
            $display("FAIL inc_dec_together: got %0d%0d want 12", bus.set_hours_tens,
                     bus.set_hours_ones);
        end
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if ({bus.field_sel, bus.set_hours_tens, bus.set_hours_ones, bus.set_minutes_ones} !==
            {2'd2, 5'd1, 5'd2, 5'd4}) begin
            errors++;
            $display("FAIL mode_beats_inc: got fs=%0d h=%0d%0d mo=%0d want 2 12 4", bus.field_sel,
                     bus.set_hours_tens, bus.set_hours_ones, bus.set_minutes_ones);
        end
        @(negedge sys_clk);
        bus.btn_inc = 1'b1;
        tick(50);
        bus.btn_inc = 1'b0;
        tick(2);
        checks++;
        if ({bus.set_minutes_tens, bus.set_minutes_ones} !== {5'd3, 5'd5}) begin
            errors++;
            $display("FAIL held_inc_once: got %0d%0d want 35", bus.set_minutes_tens,
                     bus.set_minutes_ones);
        end
        checks++;
        if (bus.field_sel !== 2'd0) begin
            errors++;
            $display("FAIL held_then_timeout: got fs=%0d want 0", bus.field_sel);
        end
    endtask

    task automatic test_timeout();
        int   exit_at;
        logic strobe_seen;
        do_reset();
        set_cur(1, 2, 3);
        exit_at     = 0;
        strobe_seen = 1'b0;
        @(negedge sys_clk);
        bus.btn_mode = 1'b1;
        tick(2);
        bus.btn_mode = 1'b0;
        for (int i = 1; i <= 40 && exit_at == 0; i++) begin
            tick(1);
            if (bus.load_strobe === 1'b1) strobe_seen = 1'b1;
            if (bus.field_sel === 2'd0) exit_at = i;
        end
        checks++;
        if (exit_at !== 20) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want 20", exit_at);
        end
        @(negedge sys_clk);
        bus.btn_mode = 1'b1;
        tick(2);
        bus.btn_mode = 1'b0;
        exit_at = 0;
        for (int i = 1; i <= 60 && exit_at == 0; i++) begin
            tick(1);
            if (i == 13) bus.btn_inc = 1'b1;
            if (i == 15) bus.btn_inc = 1'b0;
            if (bus.load_strobe === 1'b1) strobe_seen = 1'b1;
            if (bus.field_sel === 2'd0) exit_at = i;
        end
        checks++;
        if (exit_at !== 35) begin
            errors++;
            $display("FAIL timeout_restart: got %0d want 35", exit_at);
        end
        checks++;
        if (strobe_seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_no_strobe: got strobe=%b want 0", strobe_seen);
        end
        checks++;
        if ({bus.set_hours_tens, bus.set_hours_ones, bus.set_seconds_ones} !==
            {5'd0, 5'd2, 5'd3}) begin
            errors++;
            $display("FAIL timeout_held: got h=%0d%0d so=%0d want 02 3", bus.set_hours_tens,
                     bus.set_hours_ones, bus.set_seconds_ones);
        end
    endtask

    task automatic test_midedit_reset();
        logic strobe_seen;
        strobe_seen = 1'b0;
        do_reset();
        set_cur(12, 34, 56);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.field_sel !== 2'd2) begin
            errors++;
            $display("FAIL reach_set_m: got %0d want 2", bus.field_sel);
        end
        @(negedge sys_clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.field_sel, bus.set_active, bus.load_strobe, bus.set_hours_tens,
             bus.set_minutes_ones} !== {2'd0, 1'b0, 1'b0, 5'd0, 5'd0}) begin
            errors++;
            $display("FAIL async_reset: got fs=%0d act=%b ls=%b ht=%0d mo=%0d want all 0",
                     bus.field_sel, bus.set_active, bus.load_strobe, bus.set_hours_tens,
                     bus.set_minutes_ones);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (i == 2) rst = 1'b1;
            if (bus.load_strobe === 1'b1) strobe_seen = 1'b1;
        end
        checks++;
        if ({strobe_seen, bus.field_sel} !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_strobe: got strobe=%b fs=%0d want 0 0", strobe_seen,
                     bus.field_sel);
        end
    endtask

    initial begin
        test_reset();
        test_capture_commit();
        test_wrap();
        test_simultaneous();
        test_timeout();
        test_midedit_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
